// File: rtl/branch_pkg.sv
// Shared types and constants for the branch/jump resolution controller.
// Includes the branch-condition decode used during RESOLVE.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESOLVE  = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } branch_state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned LINK_OFFSET = 4;

  // Condition outcome for a conditional branch; reserved codes resolve not-taken.
  function automatic logic cond_taken(input logic [2:0] f3, input logic eq,
                                      input logic lt, input logic ltu);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = eq;
      F3_BNE:  t = !eq;
      F3_BLT:  t = lt;
      F3_BGE:  t = !lt;
      F3_BLTU: t = ltu;
      F3_BGEU: t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Operand comparator for branch resolution: equality, signed and unsigned less-than.
module branch_cmp #(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         eq,
  output logic         lt,
  output logic         ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution sequencer: captures one request, resolves condition and
// target, then drives the fetch redirect handshake and a fixed-length flush.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned n            = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         br_valid,
  output logic         br_ready,
  input  logic [2:0]   br_funct3,
  input  logic         br_jump,
  input  logic         br_jalr,
  input  logic [n-1:0] br_a,
  input  logic [n-1:0] br_b,
  input  logic [n-1:0] br_pc,
  input  logic [n-1:0] br_imm,
  output logic         redirect_valid,
  input  logic         redirect_ready,
  output logic [n-1:0] redirect_pc,
  output logic         flush,
  output logic         stall,
  output logic         res_valid,
  output logic         res_taken,
  output logic [n-1:0] res_link,
  output logic         res_err
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  branch_state_t state;

  logic [n-1:0]  a_q;
  logic [n-1:0]  b_q;
  logic [n-1:0]  pc_q;
  logic [n-1:0]  imm_q;
  logic [2:0]    f3_q;
  logic          jump_q;
  logic          jalr_q;
  logic [CW-1:0] cnt;

  logic          eq;
  logic          lt;
  logic          ltu;
  logic [n-1:0]  sum;
  logic [n-1:0]  target;
  logic [n-1:0]  link;
  logic          illegal;
  logic          raw_taken;
  logic          misaligned;
  logic          taken;
  logic          err;

  branch_cmp #(.n(n)) u_cmp (
    .a   (a_q),
    .b   (b_q),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  // Resolution from captured operands; only consumed while in RESOLVE.
  always_comb begin
    sum        = (jalr_q ? a_q : pc_q) + imm_q;
    target     = jalr_q ? {sum[n-1:1], 1'b0} : sum;
    link       = pc_q + n'(LINK_OFFSET);
    illegal    = !jump_q && ((f3_q == 3'b010) || (f3_q == 3'b011));
    raw_taken  = jump_q || (!illegal && cond_taken(f3_q, eq, lt, ltu));
    misaligned = raw_taken && target[1];
    taken      = raw_taken && !misaligned;
    err        = illegal || misaligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      br_ready       <= 1'b1;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_link       <= '0;
      res_err        <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      f3_q           <= '0;
      jump_q         <= 1'b0;
      jalr_q         <= 1'b0;
      cnt            <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (br_valid && br_ready) begin
            a_q      <= br_a;
            b_q      <= br_b;
            pc_q     <= br_pc;
            imm_q    <= br_imm;
            f3_q     <= br_funct3;
            jump_q   <= br_jump;
            jalr_q   <= br_jalr;
            br_ready <= 1'b0;
            stall    <= 1'b1;
            state    <= RESOLVE;
          end
        end
        RESOLVE: begin
          res_valid <= 1'b1;
          res_taken <= taken;
          res_link  <= link;
          res_err   <= err;
          if (taken) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
            state          <= REDIRECT;
          end else begin
            br_ready <= 1'b1;
            stall    <= 1'b0;
            state    <= IDLE;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
            cnt            <= CW'(FLUSH_CYCLES - 1);
            state          <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            flush    <= 1'b0;
            stall    <= 1'b0;
            br_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          stall          <= 1'b0;
          br_ready       <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
